lpm_result_buffer: RTL and testbench

- Downstream neighbour of the Lpm engine. It receives each lookup result from Lpm's outQ pipe, buffers it, and delivers it on the LpmIndication out method with ENA/RDY flow control.
- It also tracks lookups that are issued but not yet returned. From that count it produces a credit signal that the wrapper ANDs into request.enter__RDY, so Lpm can never hold more results than the buffer can absorb.

---
 rtl/lpm_pkg.sv | 13 +
 rtl/sync_fifo.sv | 50 +++++
 rtl/lpm_result_buffer.sv | 88 ++++++++
 tb/tb_lpm_result_buffer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/lpm_pkg.sv
// Shared types and helpers for the Lpm result path.
package lpm_pkg;

  localparam int LPM_DATA_WIDTH = 32;

  typedef logic [LPM_DATA_WIDTH-1:0] lpm_result_t;

  // Pointer width for a power-of-2 buffer: index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and an occupancy count.
// Entries are presented combinationally from the register array; there is no write-to-read bypass.
module sync_fifo
  import lpm_pkg::*;
#(
  parameter int WIDTH = LPM_DATA_WIDTH,
  parameter int DEPTH = 4,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [PW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // Full when the pointers address the same slot but sit on opposite laps.
  assign o_full    = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {(PW-1){1'b0}}};
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_rd_data = r_mem[r_rd_ptr[PW-2:0]];

  assign w_wr_acc = i_wr_en && !o_full;
  assign w_rd_acc = i_rd_en && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr[PW-2:0]] <= i_wr_data;
  end

endmodule

// File: rtl/lpm_result_buffer.sv
// Buffers Lpm lookup results for the indication port and meters lookup issue
// through a credit that counts outstanding lookups plus buffered results.
module lpm_result_buffer
  import lpm_pkg::*;
#(
  parameter int WIDTH = LPM_DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enq__ENA,
  input  logic [WIDTH-1:0] enq__v,
  output logic             enq__RDY,
  output logic             out__ENA,
  output logic [WIDTH-1:0] out__data,
  input  logic             out__RDY,
  input  logic             issue__ENA,
  output logic             credit_ok,
  output logic             err
);

  localparam int PW = ptr_width(DEPTH);

  logic             w_full;
  logic             w_empty;
  logic [PW-1:0]    w_count;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_enq_acc;
  logic             w_issue_acc;
  logic [PW:0]      w_committed;
  logic [PW-1:0]    r_inflight;
  logic [PW-1:0]    w_inflight_next;
  logic             r_err;
  logic             w_violation;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (nRST),
    .i_wr_en   (enq__ENA),
    .i_wr_data (enq__v),
    .i_rd_en   (out__RDY),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign enq__RDY  = !w_full;
  assign out__ENA  = !w_empty && out__RDY;
  assign out__data = w_empty ? '0 : w_rd_data;

  // One extra bit so inflight + occupancy cannot wrap before the compare.
  assign w_committed = {1'b0, r_inflight} + {1'b0, w_count};
  assign credit_ok   = w_committed < (PW+1)'(DEPTH);

  assign w_enq_acc   = enq__ENA && !w_full;
  assign w_issue_acc = issue__ENA && credit_ok;

  assign w_violation = (enq__ENA && w_full)
                    || (issue__ENA && !credit_ok)
                    || (w_enq_acc && (r_inflight == '0));

  // A result arriving with nothing outstanding must not drive the count negative.
  always_comb begin
    w_inflight_next = r_inflight;
    if (w_issue_acc && !w_enq_acc) begin
      w_inflight_next = r_inflight + PW'(1);
    end else if (w_enq_acc && !w_issue_acc && (r_inflight != '0)) begin
      w_inflight_next = r_inflight - PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_inflight_next;
      r_err      <= r_err || w_violation;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_lpm_result_buffer.sv
// Directed and random checks of lpm_result_buffer against a queue-based reference model.
module tb_lpm_result_buffer;
  import lpm_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        enq_ena = 1'b0;
  lpm_result_t enq_v = '0;
  logic        enq_rdy;
  logic        out_ena;
  lpm_result_t out_data;
  logic        out_rdy = 1'b0;
  logic        issue_ena = 1'b0;
  logic        credit_ok;
  logic        err;

  int checks = 0;
  int failures = 0;

  // Reference model: result queue, outstanding-lookup count, sticky error.
  lpm_result_t m_q[$];
  int          m_inflight = 0;
  bit          m_err = 1'b0;

  lpm_result_buffer #(.WIDTH(LPM_DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .CLK        (clk),
    .nRST       (n_rst),
    .enq__ENA   (enq_ena),
    .enq__v     (enq_v),
    .enq__RDY   (enq_rdy),
    .out__ENA   (out_ena),
    .out__data  (out_data),
    .out__RDY   (out_rdy),
    .issue__ENA (issue_ena),
    .credit_ok  (credit_ok),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; drives inputs, checks at the falling edge, then advances one cycle.
  task automatic tick(input bit e, input lpm_result_t v, input bit ordy, input bit iss);
    bit acc_enq, acc_deq, acc_iss, m_full, m_cred;
    int n;
    enq_ena = e; enq_v = v; out_rdy = ordy; issue_ena = iss;
    #4;
    m_full  = (m_q.size() == DEPTH);
    m_cred  = (m_inflight + m_q.size()) < DEPTH;
    acc_enq = e && !m_full;
    acc_deq = ordy && (m_q.size() != 0);
    acc_iss = iss && m_cred;
    chk("enq_rdy", 32'(enq_rdy), 32'(!m_full));
    chk("out_ena", 32'(out_ena), 32'(acc_deq));
    chk("out_data", out_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
    chk("credit_ok", 32'(credit_ok), 32'(m_cred));
    chk("err", 32'(err), 32'(m_err));
    if ((e && m_full) || (iss && !m_cred) || (acc_enq && m_inflight == 0)) m_err = 1'b1;
    n = m_inflight + int'(acc_iss) - int'(acc_enq);
    m_inflight = (n < 0) ? 0 : n;
    if (acc_deq) void'(m_q.pop_front());
    if (acc_enq) m_q.push_back(v);
    @(posedge clk); #1;
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_enq_rdy", 32'(enq_rdy), 32'd1);
    chk("rst_out_ena", 32'(out_ena), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_credit_ok", 32'(credit_ok), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    enq_ena = 1'b0; out_rdy = 1'b0; issue_ena = 1'b0;
    m_q.delete(); m_inflight = 0; m_err = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
  endtask

  initial begin
    // Power-on reset.
    #1;
    chk("por_enq_rdy", 32'(enq_rdy), 32'd1);
    chk("por_out_ena", 32'(out_ena), 32'd0);
    chk("por_credit_ok", 32'(credit_ok), 32'd1);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Basic flow: one lookup, one result presented exactly one cycle after enqueue.
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    tick(1, 32'hDEADBEEF, 1, 0);
    chk("basic_present", out_data, 32'hDEADBEEF);
    tick(0, 0, 1, 0);
    chk("basic_drained", 32'(out_ena), 32'd0);
    tick(0, 0, 1, 0);

    // Credit exhaustion: four issues close the credit, a fifth is a violation.
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);
    chk("exhaust_credit", 32'(credit_ok), 32'd0);
    tick(0, 0, 0, 1);
    chk("exhaust_err", 32'(err), 32'd1);
    for (int i = 0; i < 4; i++) tick(1, 32'hA0 + 32'(i), 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 1, 0);
    do_reset();

    // Fill under backpressure, then drain in order.
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) tick(1, 32'(i), 0, 0);
    chk("fill_full", 32'(enq_rdy), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick(0, 0, 1, 0);
      if (i == 1) chk("fill_credit_back", 32'(credit_ok), 32'd1);
    end
    tick(0, 0, 1, 0);

    // Steady state at occupancy 2 with simultaneous issue, enqueue and dequeue.
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    tick(1, 32'hF0, 0, 0);
    tick(1, 32'hF1, 0, 0);
    for (int i = 0; i < 10; i++) tick(1, 32'h100 + 32'(i), 1, 1);
    chk("steady_err", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) tick(0, 0, 1, 0);

    // Violation: result arriving with nothing outstanding is still delivered.
    do_reset();
    tick(1, 32'h55, 1, 0);
    chk("orphan_data", out_data, 32'h55);
    chk("orphan_err", 32'(err), 32'd1);
    tick(0, 0, 1, 0);

    // Reset mid-traffic with two entries buffered and one lookup outstanding.
    do_reset();
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
    tick(1, 32'h11, 0, 0);
    tick(1, 32'h22, 0, 0);
    do_reset();
    tick(0, 0, 1, 0);

    // Random traffic that obeys the protocol.
    for (int i = 0; i < 250; i++) begin
      bit e, iss;
      e   = ($urandom_range(0, 2) != 0) && (m_inflight > 0) && (m_q.size() < DEPTH);
      iss = ($urandom_range(0, 1) == 1) && ((m_inflight + m_q.size()) < DEPTH);
      tick(e, lpm_result_t'($urandom), $urandom_range(0, 2) != 0, iss);
    end

    // Unconstrained random traffic, including violations.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      tick($urandom_range(0, 1) == 1, lpm_result_t'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
